// File: rtl/pe_requant_pool.sv
// pe_requant_pool: requantizes the convolution PE's signed 24-bit results to
// int8 with rounding, optional ReLU and saturation. It can also apply 2x2,
// stride-2 max pooling, using a half-row line buffer held in flops.
module pe_requant_pool #(
    parameter int COL_W   = 28,
    parameter int ROWS    = 28,
    parameter int SHIFT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               relu_en,
    input  logic               pool_en,
    input  logic               in_valid,
    input  logic [23:0]        in_data,
    output logic               out_valid,
    output logic [7:0]         out_data,
    output logic               out_last
);

    localparam int CW    = (COL_W > 1) ? $clog2(COL_W) : 1;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int LB_N  = COL_W / 2;
    localparam int LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;

    // Rounding right shift, optional ReLU, then saturation to int8.
    // A 32-bit intermediate keeps the rounding add exact for every shift value.
    function automatic logic [7:0] requant(input logic [23:0] d,
                                           input logic [SHIFT_W-1:0] sh,
                                           input logic relu);
        logic signed [31:0] wide;
        logic signed [31:0] rnd;
        logic signed [31:0] v;
        logic signed [31:0] r;
        logic [7:0]         res;
        wide = {{8{d[23]}}, d};
        if (sh == '0) begin
            v = wide;
        end else begin
            rnd = 32'sd1 <<< (sh - {{(SHIFT_W-1){1'b0}}, 1'b1});
            v   = (wide + rnd) >>> sh;
        end
        if (relu && (v < 32'sd0)) begin
            r = 32'sd0;
        end else begin
            r = v;
        end
        if (r > 32'sd127) begin
            res = 8'h7F;
        end else if (r < -32'sd128) begin
            res = 8'h80;
        end else begin
            res = r[7:0];
        end
        return res;
    endfunction

    // Signed int8 maximum.
    function automatic logic [7:0] smax(input logic [7:0] a, input logic [7:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    logic [SHIFT_W-1:0] shift_r;
    logic               relu_r;
    logic               pool_r;
    logic [SHIFT_W-1:0] eff_shift_s;
    logic               eff_relu_s;
    logic               q_valid_r;
    logic [7:0]         q_r;
    logic [CW-1:0]      col_r;
    logic [RW-1:0]      row_r;
    logic [7:0]         hold_r;
    logic [7:0]         linebuf [LB_N];
    logic [LB_AW-1:0]   lb_idx_s;
    logic               col_end_s;
    logic               frame_last_s;
    logic [7:0]         pair_max_s;

    // A start pulse applies the port config to the sample that arrives with it.
    always_comb begin
        eff_shift_s = shift_r;
        eff_relu_s  = relu_r;
        if (start) begin
            eff_shift_s = shift;
            eff_relu_s  = relu_en;
        end else begin
            eff_shift_s = shift_r;
            eff_relu_s  = relu_r;
        end
    end

    // Window position decode and the horizontal pair maximum.
    always_comb begin
        lb_idx_s     = LB_AW'(col_r >> 1);
        col_end_s    = (col_r == CW'(COL_W - 1));
        frame_last_s = col_end_s && (row_r == RW'(ROWS - 1));
        pair_max_s   = smax(hold_r, q_r);
    end

    // Config latch, loaded on each frame start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_r <= '0;
            relu_r  <= 1'b0;
            pool_r  <= 1'b0;
        end else if (start) begin
            shift_r <= shift;
            relu_r  <= relu_en;
            pool_r  <= pool_en;
        end else begin
            shift_r <= shift_r;
            relu_r  <= relu_r;
            pool_r  <= pool_r;
        end
    end

    // Stage 1: requantize each incoming sample.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_valid_r <= 1'b0;
            q_r       <= 8'h00;
        end else begin
            q_valid_r <= in_valid;
            if (in_valid) begin
                q_r <= requant(in_data, eff_shift_s, eff_relu_s);
            end else begin
                q_r <= q_r;
            end
        end
    end

    // Row/column position of the sample currently in stage 2.
    always_ff @(posedge clk) begin
        if (!rst) begin
            col_r <= '0;
            row_r <= '0;
        end else if (start) begin
            col_r <= '0;
            row_r <= '0;
        end else if (q_valid_r) begin
            if (col_end_s) begin
                col_r <= '0;
                if (row_r == RW'(ROWS - 1)) begin
                    row_r <= '0;
                end else begin
                    row_r <= row_r + RW'(1);
                end
            end else begin
                col_r <= col_r + CW'(1);
                row_r <= row_r;
            end
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

    // Pooling storage: the left sample of each pair, and the even-row pair maxima.
    // Neither is reset; each entry is always written before it is read.
    always_ff @(posedge clk) begin
        if (rst && q_valid_r && pool_r && !col_r[0]) begin
            hold_r <= q_r;
        end else begin
            hold_r <= hold_r;
        end
        if (rst && q_valid_r && pool_r && !row_r[0] && col_r[0]) begin
            linebuf[lb_idx_s] <= pair_max_s;
        end
    end

    // Stage 2: passthrough, or the pooled output on each window's bottom-right sample.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
        end else if (q_valid_r && !pool_r) begin
            out_valid <= 1'b1;
            out_data  <= q_r;
            out_last  <= frame_last_s;
        end else if (q_valid_r && pool_r && row_r[0] && col_r[0]) begin
            out_valid <= 1'b1;
            out_data  <= smax(pair_max_s, linebuf[lb_idx_s]);
            out_last  <= frame_last_s;
        end else begin
            out_valid <= 1'b0;
            out_data  <= out_data;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pe_requant_pool.sv
// Directed bench for pe_requant_pool on a small 4x2 frame.
module tb_pe_requant_pool;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  shift;
    logic        relu_en;
    logic        pool_en;
    logic        in_valid;
    logic [23:0] in_data;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;

    int checks   = 0;
    int failures = 0;

    pe_requant_pool #(.COL_W(4), .ROWS(2), .SHIFT_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .shift    (shift),
        .relu_en  (relu_en),
        .pool_en  (pool_en),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_last (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [23:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    // Send one sample, confirm nothing appears after one cycle, then check the result after two.
    task automatic send_chk(input string tag, input logic [23:0] d, input logic ev,
                            input logic [7:0] ed, input logic el);
        send(d);
        check({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
        tick();
        check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, ev});
        check({tag, "_last"}, {31'd0, out_last}, {31'd0, el});
        if (ev) check({tag, "_data"}, {24'd0, out_data}, {24'd0, ed});
    endtask

    task automatic set_cfg(input logic [4:0] sh, input logic relu, input logic pool);
        start   = 1'b1;
        shift   = sh;
        relu_en = relu;
        pool_en = pool;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; shift = 5'd0; relu_en = 1'b0; pool_en = 1'b0;
        in_valid = 1'b0; in_data = 24'd0;
        idle(2);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {24'd0, out_data}, 32'd0);
        check("rst_last", {31'd0, out_last}, 32'd0);
        rst = 1'b1;
        idle(1);

        // Passthrough rounding and negative rounding
        set_cfg(5'd4, 1'b0, 1'b0);
        send_chk("round_pos", 24'h000128, 1'b1, 8'h13, 1'b0);
        send_chk("round_neg", 24'hFFFFE8, 1'b1, 8'hFF, 1'b0);
        set_cfg(5'd4, 1'b1, 1'b0);
        send_chk("relu_neg", 24'hFFFFE8, 1'b1, 8'h00, 1'b0);

        // Saturation, then the rest of the frame to reach out_last
        set_cfg(5'd0, 1'b0, 1'b0);
        send_chk("sat_max", 24'h7FFFFF, 1'b1, 8'h7F, 1'b0);
        send_chk("sat_min", 24'h800000, 1'b1, 8'h80, 1'b0);
        send_chk("sat_127", 24'h00007F, 1'b1, 8'h7F, 1'b0);
        send_chk("sat_m128", 24'hFFFF80, 1'b1, 8'h80, 1'b0);
        send_chk("pt_r1c0", 24'd1, 1'b1, 8'd1, 1'b0);
        send_chk("pt_r1c1", 24'd2, 1'b1, 8'd2, 1'b0);
        send_chk("pt_r1c2", 24'd3, 1'b1, 8'd3, 1'b0);
        send_chk("pt_r1c3", 24'd4, 1'b1, 8'd4, 1'b1);

        // Pooling with gaps: row0=[1,5,-3,2], row1=[4,0,7,-8]
        set_cfg(5'd0, 1'b0, 1'b1);
        send_chk("pool_a", 24'd1, 1'b0, 8'd0, 1'b0);
        idle(3);
        send_chk("pool_b", 24'd5, 1'b0, 8'd0, 1'b0);
        send_chk("pool_c", 24'hFFFFFD, 1'b0, 8'd0, 1'b0);
        idle(1);
        send_chk("pool_d", 24'd2, 1'b0, 8'd0, 1'b0);
        send_chk("pool_e", 24'd4, 1'b0, 8'd0, 1'b0);
        idle(2);
        send_chk("pool_f", 24'd0, 1'b1, 8'd5, 1'b0);
        send_chk("pool_g", 24'd7, 1'b0, 8'd0, 1'b0);
        idle(4);
        send_chk("pool_h", 24'hFFFFF8, 1'b1, 8'd7, 1'b1);
        tick();
        check("pool_hold_valid", {31'd0, out_valid}, 32'd0);
        check("pool_hold_data", {24'd0, out_data}, 32'd7);

        // Abandoned partial pooled frame, then a full frame
        set_cfg(5'd0, 1'b0, 1'b1);
        send_chk("part_a", 24'd10, 1'b0, 8'd0, 1'b0);
        send_chk("part_b", 24'd20, 1'b0, 8'd0, 1'b0);
        send_chk("part_c", 24'd30, 1'b0, 8'd0, 1'b0);
        idle(2);
        set_cfg(5'd0, 1'b0, 1'b1);
        tick();
        start = 1'b0;
        check("restart_quiet", {31'd0, out_valid}, 32'd0);
        send_chk("full_a", 24'hFFFFFB, 1'b0, 8'd0, 1'b0);
        send_chk("full_b", 24'hFFFFFA, 1'b0, 8'd0, 1'b0);
        send_chk("full_c", 24'hFFFFF9, 1'b0, 8'd0, 1'b0);
        send_chk("full_d", 24'hFFFFF7, 1'b0, 8'd0, 1'b0);
        send_chk("full_e", 24'hFFFFFF, 1'b0, 8'd0, 1'b0);
        send_chk("full_f", 24'hFFFF9C, 1'b1, 8'hFF, 1'b0);
        send_chk("full_g", 24'd3, 1'b0, 8'd0, 1'b0);
        send_chk("full_h", 24'hFFFFFE, 1'b1, 8'd3, 1'b1);

        // Reset mid-frame during a passthrough stream
        set_cfg(5'd2, 1'b0, 1'b0);
        send_chk("pre_rst", 24'd40, 1'b1, 8'd10, 1'b0);
        in_valid = 1'b1;
        in_data  = 24'd100;
        tick();
        rst     = 1'b0;
        in_data = 24'd200;
        tick();
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_last", {31'd0, out_last}, 32'd0);
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        check("midrst_drop", {31'd0, out_valid}, 32'd0);
        send_chk("post_rst_dflt", 24'h000055, 1'b1, 8'h55, 1'b0);
        set_cfg(5'd1, 1'b0, 1'b0);
        send_chk("post_rst_cfg", 24'd7, 1'b1, 8'd4, 1'b0);
        send_chk("post_rst_c1", 24'd9, 1'b1, 8'd5, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
